// File: rtl/jtcps1_gfx_pkg.sv
// Shared constants for the CPS1 graphics-ROM arbiter: FSM encoding, requester
// indices and default bus widths.
package jtcps1_gfx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } gfx_state_t;

  localparam int REQ_OBJ  = 0;
  localparam int REQ_SCR1 = 1;
  localparam int REQ_SCR2 = 2;
  localparam int REQ_SCR3 = 3;

  localparam int GFX_N  = 4;
  localparam int GFX_AW = 20;
  localparam int GFX_DW = 32;

  // Index width for n requesters, never below one bit.
  function automatic int gfx_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jtcps1_gfx_pick.sv
// Grant picker: first pending requester searched from a start index.
// GFXARB_RR_EN defined: search starts at i_ptr (round robin); otherwise at 0.
module jtcps1_gfx_pick
  import jtcps1_gfx_pkg::*;
#(
  parameter  int N  = GFX_N,
  localparam int IW = gfx_idx_w(N)
) (
  input  logic [N-1:0]  i_pend,
  input  logic [IW-1:0] i_ptr,
  output logic          o_any,
  output logic [IW-1:0] o_idx,
  output logic [N-1:0]  o_oh
);

  logic [IW-1:0] w_start;
  logic [IW-1:0] w_cand;

`ifdef GFXARB_RR_EN
  assign w_start = i_ptr;
`else
  logic w_unused_ptr;
  assign w_start      = '0;
  assign w_unused_ptr = ^i_ptr;
`endif

  always_comb begin
    o_any  = 1'b0;
    o_idx  = '0;
    o_oh   = '0;
    w_cand = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = IW'((int'(w_start) + k) % N);
      if (!o_any && i_pend[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
    if (o_any) o_oh[o_idx] = 1'b1;
  end

endmodule

// File: rtl/jtcps1_gfx_arb.sv
// Shares one graphics-ROM read port among the object drawer and three scroll
// fetchers, with a one-entry result cache per requester. Macro: GFXARB_RR_EN.
module jtcps1_gfx_arb
  import jtcps1_gfx_pkg::*;
#(
  parameter int N  = GFX_N,
  parameter int AW = GFX_AW,
  parameter int DW = GFX_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N-1:0]  req_half,
  input  logic [N-1:0]  req_cs,
  output logic [N*DW-1:0] req_data,
  output logic [N-1:0]  req_ok,
  output logic [AW-1:0] rom_addr,
  output logic          rom_half,
  output logic          rom_cs,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok,
  output gfx_state_t    dbg_state
);

  localparam int IW = gfx_idx_w(N);

  // Handshake: a requester holds cs with a stable addr/half; ok means data
  // matches that addr/half this cycle. ROM side: rom_cs stays high with a
  // stable addr/half until the single-cycle rom_ok, then drops for a gap.

  gfx_state_t      r_state, w_state_nxt;
  logic [IW-1:0]   r_grant, r_ptr;
  logic [AW-1:0]   r_rom_addr;
  logic            r_rom_half, r_rom_cs;
  logic [N-1:0]    r_valid, r_tag_half;
  logic [AW-1:0]   r_tag_addr [N];
  logic [DW-1:0]   r_data [N];

  logic [N-1:0]    w_hit, w_pend, w_pick_oh;
  logic            w_busy, w_pick_any, w_issue, w_fill;
  logic [IW-1:0]   w_pick_idx;
  logic [AW-1:0]   w_sel_addr;
  logic            w_sel_half;

  always_comb begin
    w_hit    = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      w_hit[i] = r_valid[i] && (r_tag_addr[i] == req_addr[i*AW +: AW])
                 && (r_tag_half[i] == req_half[i]);
      req_data[i*DW +: DW] = r_data[i];
    end
  end

  assign req_ok = req_cs & w_hit;
  assign w_busy = (r_state != ST_IDLE);

  // The requester being served is never pending again until its fill lands.
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < N; i++) begin
      w_pend[i] = req_cs[i] & ~req_ok[i] & ~(w_busy && (r_grant == IW'(i)));
    end
  end

  jtcps1_gfx_pick #(.N(N)) u_pick (
    .i_pend (w_pend),
    .i_ptr  (r_ptr),
    .o_any  (w_pick_any),
    .o_idx  (w_pick_idx),
    .o_oh   (w_pick_oh)
  );

  always_comb begin
    w_sel_addr = '0;
    w_sel_half = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_pick_oh[i]) begin
        w_sel_addr = w_sel_addr | req_addr[i*AW +: AW];
        w_sel_half = w_sel_half | req_half[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_fill      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rom_ok) begin
          w_fill      = 1'b1;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_ptr      <= '0;
      r_rom_addr <= '0;
      r_rom_half <= 1'b0;
      r_rom_cs   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_grant    <= w_pick_idx;
        r_rom_addr <= w_sel_addr;
        r_rom_half <= w_sel_half;
        r_rom_cs   <= 1'b1;
`ifdef GFXARB_RR_EN
        r_ptr      <= (w_pick_idx == IW'(N-1)) ? '0 : w_pick_idx + 1'b1;
`endif
      end else if (w_fill) begin
        r_rom_cs <= 1'b0;
      end
    end
  end

  // The fill uses the issued tag, so an addr change mid-flight shows as a miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= '0;
      r_tag_half <= '0;
      for (int i = 0; i < N; i++) begin
        r_tag_addr[i] <= '0;
        r_data[i]     <= '0;
      end
    end else if (w_fill) begin
      r_valid[r_grant]    <= 1'b1;
      r_tag_addr[r_grant] <= r_rom_addr;
      r_tag_half[r_grant] <= r_rom_half;
      r_data[r_grant]     <= rom_data;
    end
  end

  assign rom_addr  = r_rom_addr;
  assign rom_half  = r_rom_half;
  assign rom_cs    = r_rom_cs;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_jtcps1_gfx_arb.sv
// Bench for jtcps1_gfx_arb: directed scenarios plus random traffic, checked
// against a transaction-level model of the cache and arbitration rules.
module tb_jtcps1_gfx_arb;
  import jtcps1_gfx_pkg::*;

  localparam int N  = 4;
  localparam int AW = 20;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_half = '0;
  logic [N-1:0]    req_cs = '0;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ok;
  logic [AW-1:0]   rom_addr;
  logic            rom_half, rom_cs;
  logic [DW-1:0]   rom_data = '0;
  logic            rom_ok = 1'b0;
  gfx_state_t      dbg_state;

  jtcps1_gfx_arb #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_addr(req_addr), .req_half(req_half), .req_cs(req_cs),
    .req_data(req_data), .req_ok(req_ok),
    .rom_addr(rom_addr), .rom_half(rom_half), .rom_cs(rom_cs),
    .rom_data(rom_data), .rom_ok(rom_ok),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: per-requester cache plus the ROM port occupancy.
  logic          m_valid [N];
  logic [AW-1:0] m_tag_a [N];
  logic          m_tag_h [N];
  logic [DW-1:0] m_data  [N];
  bit            m_busy;
  int            m_g, m_lat, m_free, cyc;
  logic [AW-1:0] m_addr;
  logic          m_half;
`ifdef GFXARB_RR_EN
  int            m_ptr;
`endif
  int            lat_fix;
  bit            stray_en, stray_force, prev_cs;
  logic [AW:0]   exp_q[$];
  logic [AW-1:0] issue_q[$];
  int            n_checks, n_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a, input logic h);
    logic [31:0] x;
    x = {11'd0, a, h};
    return (x * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic int pick_model(input logic [N-1:0] p);
    int s = 0;
`ifdef GFXARB_RR_EN
    s = m_ptr;
`endif
    for (int k = 0; k < N; k++) if (p[(s + k) % N]) return (s + k) % N;
    return 0;
  endfunction

  function automatic bit model_hit(input int i);
    return m_valid[i] && (m_tag_a[i] == req_addr[i*AW +: AW]) && (m_tag_h[i] == req_half[i]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_tag_a[i] = '0; m_tag_h[i] = 1'b0; m_data[i] = '0;
    end
    m_busy = 1'b0; m_free = 0; prev_cs = 1'b0;
`ifdef GFXARB_RR_EN
    m_ptr = 0;
`endif
    exp_q.delete();
  endtask

  task automatic set_req(input int i, input bit cs, input logic [AW-1:0] a, input logic h);
    req_cs[i] = cs;
    req_addr[i*AW +: AW] = a;
    req_half[i] = h;
  endtask

  // One clock: drive ROM response, check combinational outputs, advance model, check registers.
  task automatic cycle();
    logic [N-1:0] pend;
    int g;
    if (m_busy) begin
      if (m_lat == 0) begin rom_ok = 1'b1; rom_data = mem_fn(m_addr, m_half); end
      else begin rom_ok = 1'b0; rom_data = $urandom; m_lat--; end
    end else begin
      rom_ok = stray_force || (stray_en && ($urandom_range(0, 3) == 0));
      rom_data = $urandom;
    end
    stray_force = 1'b0;
    #1;
    pend = '0;
    for (int i = 0; i < N; i++) begin
      check($sformatf("req_ok[%0d]", i), req_ok[i], req_cs[i] & model_hit(i));
      check($sformatf("req_data[%0d]", i), req_data[i*DW +: DW], m_data[i]);
      pend[i] = req_cs[i] & ~model_hit(i);
    end
    g = -1;
    if (m_busy && rom_ok) begin
      m_valid[m_g] = 1'b1; m_tag_a[m_g] = m_addr; m_tag_h[m_g] = m_half;
      m_data[m_g] = mem_fn(m_addr, m_half);
      m_busy = 1'b0;
      m_free = cyc + 2;
    end else if (!m_busy && cyc >= m_free && pend != '0) begin
      g = pick_model(pend);
      m_busy = 1'b1; m_g = g;
      m_addr = req_addr[g*AW +: AW]; m_half = req_half[g];
      m_lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 4));
      exp_q.push_back({m_addr, m_half});
`ifdef GFXARB_RR_EN
      m_ptr = (g + 1) % N;
`endif
    end
    @(posedge clk);
    cyc++;
    #1;
    check("rom_cs", rom_cs, m_busy);
    if (g >= 0) check("rom_issue", {rom_addr, rom_half}, exp_q.pop_front());
    else if (m_busy) check("rom_hold", {rom_addr, rom_half}, {m_addr, m_half});
    if (rom_cs && !prev_cs) issue_q.push_back(rom_addr);
    prev_cs = rom_cs;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_cs"}, rom_cs, 1'b0);
    check({tag, "_rom_addr"}, rom_addr, '0);
    check({tag, "_rom_half"}, rom_half, 1'b0);
    check({tag, "_req_ok"}, req_ok, '0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
    for (int i = 0; i < N; i++) check({tag, "_data"}, req_data[i*DW +: DW], '0);
  endtask

  initial begin
    logic [AW-1:0] pool [4];
    int cnt [N];
    int ctr, total;
    pool[0] = 20'h01234; pool[1] = 20'h00010; pool[2] = 20'h00020; pool[3] = 20'hABCDE;
    n_checks = 0; n_bad = 0; cyc = 0; lat_fix = -1; stray_en = 1'b0; stray_force = 1'b0;
    model_clear();

    // Power-on reset
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single miss on the object drawer
    lat_fix = 3;
    issue_q.delete();
    set_req(REQ_OBJ, 1'b1, 20'h01234, 1'b0);
    run(8);
    check("t1_issue_n", issue_q.size(), 1);
    check("t1_addr", (issue_q.size() > 0) ? issue_q[0] : '1, 20'h01234);
    check("t1_ok", req_ok, 4'b0001);
    check("t1_data", req_data[DW-1:0], mem_fn(20'h01234, 1'b0));

    // Half toggles: each change misses the one-entry cache
    set_req(REQ_OBJ, 1'b1, 20'h01234, 1'b1);
    run(8);
    check("t2_ok_h1", req_ok[0], 1'b1);
    set_req(REQ_OBJ, 1'b1, 20'h01234, 1'b0);
    cycle();
    check("t2_miss_h0", req_ok[0], 1'b0);
    run(8);

    // Simultaneous requests from 0 and 2
    issue_q.delete();
    set_req(REQ_OBJ, 1'b1, 20'h00100, 1'b0);
    set_req(REQ_SCR2, 1'b1, 20'h00200, 1'b0);
    run(16);
    check("t3_issue_n", issue_q.size(), 2);
`ifdef GFXARB_RR_EN
    check("t3_first", (issue_q.size() > 0) ? issue_q[0] : '1, 20'h00200);
`else
    check("t3_first", (issue_q.size() > 0) ? issue_q[0] : '1, 20'h00100);
`endif

    // Address change while in flight
    set_req(REQ_OBJ, 1'b0, 20'h00100, 1'b0);
    set_req(REQ_SCR2, 1'b0, 20'h00200, 1'b0);
    issue_q.delete();
    lat_fix = 4;
    set_req(REQ_SCR1, 1'b1, 20'h00010, 1'b0);
    run(3);
    set_req(REQ_SCR1, 1'b1, 20'h00020, 1'b0);
    run(16);
    check("t4_issue_n", issue_q.size(), 2);
    check("t4_first", (issue_q.size() > 0) ? issue_q[0] : '1, 20'h00010);
    check("t4_second", (issue_q.size() > 1) ? issue_q[1] : '1, 20'h00020);
    check("t4_ok", req_ok[1], 1'b1);

    // Asynchronous reset while waiting on the ROM
    set_req(REQ_SCR1, 1'b0, 20'h00020, 1'b0);
    lat_fix = 6;
    set_req(REQ_SCR3, 1'b1, 20'h00777, 1'b1);
    run(2);
    check("t5_busy", rom_cs, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t5");
    model_clear();
    @(negedge clk);
    rom_ok = 1'b1; rom_data = 32'hDEADBEEF;
    @(negedge clk);
    rst_n = 1'b1;
    stray_force = 1'b1;
    lat_fix = 2;
    run(10);
    check("t5_ok", req_ok[3], 1'b1);
    check("t5_data", req_data[3*DW +: DW], mem_fn(20'h00777, 1'b1));

    // All four requesters keep missing
    lat_fix = -1;
    ctr = 0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'((i << 16) | 1), 1'b0);
    issue_q.delete();
    for (int k = 0; k < 240; k++) begin
      for (int i = 0; i < N; i++)
        if (model_hit(i)) begin ctr++; set_req(i, 1'b1, AW'((i << 16) | ctr + 2), 1'b0); end
      cycle();
    end
    for (int i = 0; i < N; i++) cnt[i] = 0;
    foreach (issue_q[j]) cnt[int'(issue_q[j][17:16])]++;
    total = issue_q.size();
`ifdef GFXARB_RR_EN
    for (int i = 0; i < N; i++) begin
      check($sformatf("t6_fair_lo[%0d]", i), cnt[i] >= total / N, 1'b1);
      check($sformatf("t6_fair_hi[%0d]", i), cnt[i] <= total / N + 1, 1'b1);
    end
`else
    check("t6_obj_wins", cnt[REQ_OBJ], total);
`endif
    check("t6_progress", total >= 30, 1'b1);

    // Random traffic
    stray_en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0)
          set_req(i, $urandom_range(0, 3) != 0, pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
